pipelined_barrel_rotator: RTL

Pipelined variable-amount circular shifter with a selectable direction.
- Rotates an N-bit word left or right by 0..N-1 positions.
- Accepts one word per clock with no backpressure; each result appears a fixed number of cycles after its input.
- Serves as the runtime-programmable rotate stage in the arithmetic datapath, and undoes (right) or applies (left) the fixed rotations used elsewhere in the design.

---
 rtl/pipelined_barrel_rotator_if.sv | 24 ++
 rtl/pipelined_barrel_rotator.sv | 77 +++++++
 2 files changed

// File: rtl/pipelined_barrel_rotator_if.sv
// Stream interface for the pipelined barrel rotator: one upstream word in,
// one rotated word out, no backpressure.
interface pipelined_barrel_rotator_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         up_valid;
    logic [N-1:0] up_data;
    logic [W-1:0] up_amt;
    logic         up_dir;
    logic         down_valid;
    logic [N-1:0] down_data;

    modport master (
        output up_valid, up_data, up_amt, up_dir,
        input  down_valid, down_data
    );

    modport slave (
        input  up_valid, up_data, up_amt, up_dir,
        output down_valid, down_data
    );
endinterface

// File: rtl/pipelined_barrel_rotator.sv
// Pipelined circular shifter: stage k rotates by 2^k when amount bit k is set,
// with the direction and remaining amount bits travelling alongside the word.
module pipelined_barrel_rotator #(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_barrel_rotator_if.slave  bus
);
    localparam int W = $clog2(N);

    for (genvar k = 0; k < W; k++) begin : g_stage
        localparam int S = 1 << k;

        logic           in_vld;
        logic           in_dir;
        logic [N-1:0]   in_data;
        logic [W-k-1:0] in_amt;   // amount bits k..W-1; bit 0 drives this stage

        logic           vld_q;
        logic [N-1:0]   data_q;
        logic [N-1:0]   data_d;

        if (k == 0) begin : g_src
            assign in_vld  = bus.up_valid;
            assign in_dir  = bus.up_dir;
            assign in_data = bus.up_data;
            assign in_amt  = bus.up_amt;
        end else begin : g_src
            assign in_vld  = g_stage[k-1].vld_q;
            assign in_dir  = g_stage[k-1].g_carry.dir_q;
            assign in_data = g_stage[k-1].data_q;
            assign in_amt  = g_stage[k-1].g_carry.amt_q;
        end

        always_comb begin
            data_d = in_data;
            if (in_amt[0]) begin
                if (in_dir) data_d = {in_data[S-1:0], in_data[N-1:S]};
                else        data_d = {in_data[N-1-S:0], in_data[N-1:N-S]};
            end
        end

        // NOTE: non-blocking assignments keep every stage reading the previous
        // stage's value from before the edge, which is what makes this a pipeline.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                // NOTE: data is reset as well so down_data reads 0 until the first
                // result instead of exposing stale contents.
                data_q <= '0;
            end else begin
                vld_q <= in_vld;
                if (in_vld) data_q <= data_d;
            end
        end

        // The final stage has no later consumer for direction or amount bits.
        if (k < W - 1) begin : g_carry
            logic           dir_q;
            logic [W-k-2:0] amt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dir_q <= 1'b0;
                    amt_q <= '0;
                end else if (in_vld) begin
                    dir_q <= in_dir;
                    amt_q <= in_amt[W-k-1:1];
                end
            end
        end
    end

    assign bus.down_valid = g_stage[W-1].vld_q;
    assign bus.down_data  = g_stage[W-1].data_q;
endmodule
